// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor
// -----------------------------------------------------------------------------
// Watches the spike line of a LIF neuron and turns it into two measurements:
//   * a windowed spike-rate count, offered through a valid/ready handshake
//   * the inter-spike interval (ISI) between the last two rising edges,
//     announced by a one-cycle valid pulse
//
// A level held high on spike_in_i for several cycles counts as a single spike
// (only rising edges are counted).
//
// Optional feature macro: SPIKE_MON_SEG7_EN
//   defined   -> seg_out_o is a registered hex decode of rate_count_o[3:0]
//   undefined -> seg_out_o is tied low and no decoder is built
//
// Ports
//   clk_i           clock, everything on the rising edge
//   rst_i           synchronous active-high reset
//   en_i            measurement enable; low forces the window FSM to IDLE
//   spike_in_i      spike level from the neuron
//   window_len_i    window length minus one, sampled at each window start
//   rate_count_o    spike count of the last completed window (saturating)
//   rate_valid_o    rate_count_o holds a result not yet consumed
//   rate_ready_i    consumer accepts the result when valid and ready
//   rate_overrun_o  sticky flag: an unconsumed result was overwritten
//   isi_o           cycles between the last two spike edges (saturating)
//   isi_valid_o     one-cycle pulse when isi_o updates
//   seg_out_o       7-segment pattern {g,f,e,d,c,b,a}, active high
// -----------------------------------------------------------------------------
module lif_spike_monitor #(
    parameter int WINDOW_W = 10,
    parameter int CNT_W    = 8,
    parameter int ISI_W    = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                spike_in_i,
    input  logic [WINDOW_W-1:0] window_len_i,
    output logic [CNT_W-1:0]    rate_count_o,
    output logic                rate_valid_o,
    input  logic                rate_ready_i,
    output logic                rate_overrun_o,
    output logic [ISI_W-1:0]    isi_o,
    output logic                isi_valid_o,
    output logic [6:0]          seg_out_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    state_t              state_q, state_d;
    logic                spike_prev_q;
    logic [WINDOW_W-1:0] win_len_q, win_len_d;
    logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    spike_cnt_q, spike_cnt_d;
    logic [CNT_W-1:0]    rate_count_q, rate_count_d;
    logic                rate_valid_q, rate_valid_d;
    logic                rate_overrun_q, rate_overrun_d;
    logic                armed_q, armed_d;
    logic [ISI_W-1:0]    isi_timer_q, isi_timer_d;
    logic [ISI_W-1:0]    isi_q, isi_d;
    logic                isi_valid_q, isi_valid_d;

    logic                spike_event;
    logic [CNT_W-1:0]    spike_cnt_sat;
    logic                new_result;

    // Rising edge of the spike line, and the window count including this
    // cycle's edge. The same saturated sum feeds both the running count and
    // the result captured in the last window cycle, so a spike landing on the
    // final cycle is still credited to the window it belongs to.
    assign spike_event   = spike_in_i & ~spike_prev_q;
    assign spike_cnt_sat = (spike_event && (spike_cnt_q != CNT_MAX))
                         ? spike_cnt_q + CNT_W'(1) : spike_cnt_q;

    // Next-state logic for the window FSM, the rate output mailbox and the
    // ISI tracker. Windows run back to back while enabled: the last window
    // cycle hands its count to the output register and reloads the window
    // length in the same step, so there is no idle gap between windows.
    // Dropping enable throws away the partial window without producing a
    // result. The ISI tracker is independent of the window FSM and only
    // needs enable; it starts timing on the first edge after being armed.
    always_comb begin
        state_d        = state_q;
        win_len_d      = win_len_q;
        win_cnt_d      = win_cnt_q;
        spike_cnt_d    = spike_cnt_q;
        rate_count_d   = rate_count_q;
        rate_valid_d   = rate_valid_q;
        rate_overrun_d = rate_overrun_q;
        armed_d        = armed_q;
        isi_timer_d    = isi_timer_q;
        isi_d          = isi_q;
        isi_valid_d    = 1'b0;
        new_result     = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d     = RUN;
                    win_len_d   = window_len_i;
                    win_cnt_d   = '0;
                    spike_cnt_d = '0;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (win_cnt_q == win_len_q) begin
                    new_result  = 1'b1;
                    win_len_d   = window_len_i;
                    win_cnt_d   = '0;
                    spike_cnt_d = '0;
                end else begin
                    spike_cnt_d = spike_cnt_sat;
                    win_cnt_d   = win_cnt_q + WINDOW_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh result always wins over the handshake: it is loaded and
        // stays valid. Overrun is flagged only when the old result was still
        // waiting and nobody took it in this cycle.
        if (new_result) begin
            rate_count_d = spike_cnt_sat;
            rate_valid_d = 1'b1;
            if (rate_valid_q && !rate_ready_i) begin
                rate_overrun_d = 1'b1;
            end
        end else if (rate_valid_q && rate_ready_i) begin
            rate_valid_d = 1'b0;
        end

        // The timer restarts at 1 on every edge, so at the next edge it holds
        // exactly the number of cycles between the two edges.
        if (!en_i) begin
            armed_d     = 1'b0;
            isi_timer_d = '0;
        end else if (spike_event) begin
            if (armed_q) begin
                isi_d       = isi_timer_q;
                isi_valid_d = 1'b1;
            end
            armed_d     = 1'b1;
            isi_timer_d = ISI_W'(1);
        end else if (armed_q && (isi_timer_q != ISI_MAX)) begin
            isi_timer_d = isi_timer_q + ISI_W'(1);
        end
    end

    // State register for everything above. Reset clears every register,
    // including the sticky overrun flag, which nothing else can clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            spike_prev_q   <= 1'b0;
            win_len_q      <= '0;
            win_cnt_q      <= '0;
            spike_cnt_q    <= '0;
            rate_count_q   <= '0;
            rate_valid_q   <= 1'b0;
            rate_overrun_q <= 1'b0;
            armed_q        <= 1'b0;
            isi_timer_q    <= '0;
            isi_q          <= '0;
            isi_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            spike_prev_q   <= spike_in_i;
            win_len_q      <= win_len_d;
            win_cnt_q      <= win_cnt_d;
            spike_cnt_q    <= spike_cnt_d;
            rate_count_q   <= rate_count_d;
            rate_valid_q   <= rate_valid_d;
            rate_overrun_q <= rate_overrun_d;
            armed_q        <= armed_d;
            isi_timer_q    <= isi_timer_d;
            isi_q          <= isi_d;
            isi_valid_q    <= isi_valid_d;
        end
    end

    assign rate_count_o   = rate_count_q;
    assign rate_valid_o   = rate_valid_q;
    assign rate_overrun_o = rate_overrun_q;
    assign isi_o          = isi_q;
    assign isi_valid_o    = isi_valid_q;

`ifdef SPIKE_MON_SEG7_EN
    logic [6:0] seg_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b0111111;
            4'h1: pat = 7'b0000110;
            4'h2: pat = 7'b1011011;
            4'h3: pat = 7'b1001111;
            4'h4: pat = 7'b1100110;
            4'h5: pat = 7'b1101101;
            4'h6: pat = 7'b1111101;
            4'h7: pat = 7'b0000111;
            4'h8: pat = 7'b1111111;
            4'h9: pat = 7'b1101111;
            4'hA: pat = 7'b1110111;
            4'hB: pat = 7'b1111100;
            4'hC: pat = 7'b0111001;
            4'hD: pat = 7'b1011110;
            4'hE: pat = 7'b1111001;
            default: pat = 7'b1110001;
        endcase
        return pat;
    endfunction

    // Display register follows the rate register one cycle later, which
    // keeps the decoder off the handshake timing path.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_q <= '0;
        end else begin
            seg_q <= hex_to_seg(rate_count_q[3:0]);
        end
    end

    assign seg_out_o = seg_q;
`else
    assign seg_out_o = 7'b0000000;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// tb_lif_spike_monitor
// -----------------------------------------------------------------------------
// Testbench for lif_spike_monitor. A behavioural model, stepped once per
// cycle alongside the stimulus, counts spike edges per window and timestamps
// edges for the interval measurement; its predictions go into queues that a
// separate monitor drains whenever the DUT completes a rate handshake or
// pulses isi_valid.
// -----------------------------------------------------------------------------
module tb_lif_spike_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       spike_in = 1'b0;
    logic [9:0] window_len = '0;
    logic       rate_ready = 1'b0;
    logic [7:0] rate_count;
    logic       rate_valid;
    logic       rate_overrun;
    logic [11:0] isi;
    logic       isi_valid;
    logic [6:0] seg_out;

    int testsRun = 0;
    int failures = 0;

    int rateQ[$];
    int isiQ[$];

    bit mPrev = 0;
    bit mRun = 0;
    int mLen = 0;
    int mCyc = 0;
    int mEvents = 0;
    bit mPendValid = 0;
    int mPendVal = 0;
    bit mOverrun = 0;
    bit mArmed = 0;
    int mLastEdge = 0;
    int cyc = 0;

    lif_spike_monitor #(
        .WINDOW_W(10),
        .CNT_W(8),
        .ISI_W(12)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .spike_in_i(spike_in),
        .window_len_i(window_len),
        .rate_count_o(rate_count),
        .rate_valid_o(rate_valid),
        .rate_ready_i(rate_ready),
        .rate_overrun_o(rate_overrun),
        .isi_o(isi),
        .isi_valid_o(isi_valid),
        .seg_out_o(seg_out)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // One comparison: counts it and reports any disagreement.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference behaviour for the cycle whose inputs were just applied.
    // Rate: edges are tallied per window of len+1 enabled cycles; a finished
    // window becomes the offered result, and the consumer takes whatever
    // result is on offer in any cycle where ready is high.
    // ISI: the distance in cycles between consecutive enabled edges.
    task automatic modelStep();
        bit ev;
        bit hs;
        bit newRes;
        int resVal;
        cyc++;
        if (rst) begin
            mPrev = 0; mRun = 0; mLen = 0; mCyc = 0; mEvents = 0;
            mPendValid = 0; mPendVal = 0; mOverrun = 0; mArmed = 0;
            rateQ.delete();
            isiQ.delete();
        end else begin
            ev = spike_in && !mPrev;
            mPrev = spike_in;
            newRes = 0;
            resVal = 0;
            hs = mPendValid && rate_ready;
            if (!mRun) begin
                if (en) begin
                    mRun = 1; mLen = int'(window_len); mCyc = 0; mEvents = 0;
                end
            end else if (!en) begin
                mRun = 0;
            end else begin
                mEvents += int'(ev);
                mCyc++;
                if (mCyc == mLen + 1) begin
                    newRes = 1;
                    resVal = (mEvents > 255) ? 255 : mEvents;
                    mLen = int'(window_len); mCyc = 0; mEvents = 0;
                end
            end
            if (hs) rateQ.push_back(mPendVal);
            if (newRes) begin
                if (mPendValid && !rate_ready) mOverrun = 1;
                mPendVal = resVal;
                mPendValid = 1;
            end else if (hs) begin
                mPendValid = 0;
            end
            if (!en) begin
                mArmed = 0;
            end else if (ev) begin
                if (mArmed) isiQ.push_back(((cyc - mLastEdge) > 4095) ? 4095 : (cyc - mLastEdge));
                mArmed = 1;
                mLastEdge = cyc;
            end
        end
    endtask

    // Drive one cycle of inputs, update the model, and return just after
    // the edge that consumes them.
    task automatic applyStimulus(input bit r, input bit e, input bit s, input int wl, input bit rd);
        rst = r;
        en = e;
        spike_in = s;
        window_len = wl[9:0];
        rate_ready = rd;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // One disabled cycle: FSM back to IDLE, ISI disarmed.
    task automatic restart(input int wl);
        applyStimulus(0, 0, 0, wl, 1);
    endtask

    // Scoreboard monitor, sampling on the falling edge away from the
    // active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rate_valid && rate_ready) begin
                if (rateQ.size() == 0) begin
                    checkOutput("rate_unexpected_handshake", 1, 0);
                end else begin
                    checkOutput("rate_count", rate_count, rateQ.pop_front());
                end
            end
            if (isi_valid) begin
                if (isiQ.size() == 0) begin
                    checkOutput("isi_unexpected_pulse", 1, 0);
                end else begin
                    checkOutput("isi", isi, isiQ.pop_front());
                end
            end
        end
    end

    initial begin
        bit sawValid;
        int wlR;

        // Reset state
        applyStimulus(1, 0, 0, 9, 1);
        applyStimulus(1, 0, 0, 9, 1);
        checkOutput("reset_rate_count", rate_count, 0);
        checkOutput("reset_rate_valid", rate_valid, 0);
        checkOutput("reset_overrun", rate_overrun, 0);
        checkOutput("reset_isi", isi, 0);
        checkOutput("reset_isi_valid", isi_valid, 0);
        checkOutput("reset_seg", seg_out, 0);

        // Three single-cycle spikes in a 10-cycle window
        applyStimulus(0, 1, 0, 9, 1);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, (k == 2 || k == 5 || k == 8), 9, 1);
        checkOutput("t1_count", rate_count, 3);
        checkOutput("t1_valid_on", rate_valid, 1);
        applyStimulus(0, 1, 0, 9, 1);
        checkOutput("t1_valid_one_cycle", rate_valid, 0);
`ifdef SPIKE_MON_SEG7_EN
        checkOutput("t1_seg", seg_out, 7'b1001111);
`else
        checkOutput("t1_seg", seg_out, 0);
`endif

        // A level held high four cycles counts once
        restart(9);
        applyStimulus(0, 1, 0, 9, 1);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, (k >= 3 && k <= 6), 9, 1);
        checkOutput("t2_count", rate_count, 1);

        // Edges 7 then 20 cycles apart
        restart(9);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 1, (i == 2 || i == 9 || i == 29), 9, 1);
            if (i == 2) checkOutput("t3_first_edge_no_isi", isi_valid, 0);
            if (i == 9) begin
                checkOutput("t3_isi7_valid", isi_valid, 1);
                checkOutput("t3_isi7", isi, 7);
            end
            if (i == 10) checkOutput("t3_isi_pulse_len", isi_valid, 0);
            if (i == 29) begin
                checkOutput("t3_isi20_valid", isi_valid, 1);
                checkOutput("t3_isi20", isi, 20);
            end
        end

        // Back-pressure across two windows: 2 spikes, then 5
        restart(9);
        applyStimulus(0, 1, 0, 9, 0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, (k == 1 || k == 3), 9, 0);
        checkOutput("t4_first_count", rate_count, 2);
        checkOutput("t4_no_overrun_yet", rate_overrun, 0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, (k % 2 == 1), 9, 0);
        checkOutput("t4_count", rate_count, 5);
        checkOutput("t4_valid", rate_valid, 1);
        checkOutput("t4_overrun", rate_overrun, 1);
        checkOutput("t4_overrun_model", rate_overrun, mOverrun);
        applyStimulus(0, 1, 0, 9, 1);
        checkOutput("t4_handshake_clears_valid", rate_valid, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 9, 1);
        checkOutput("t4_overrun_sticky", rate_overrun, 1);
        applyStimulus(1, 0, 0, 9, 1);
        checkOutput("t4_overrun_cleared_by_reset", rate_overrun, 0);

        // Longest window with a toggling spike line saturates the count
        restart(1023);
        applyStimulus(0, 1, 0, 1023, 1);
        for (int k = 0; k < 1024; k++) applyStimulus(0, 1, (k % 2 == 1), 1023, 1);
        checkOutput("t5_rate_saturated", rate_count, 255);

        // Long silence after arming saturates the interval
        restart(1023);
        for (int i = 0; i < 5002; i++) applyStimulus(0, 1, (i == 1 || i == 5001), 1023, 1);
        checkOutput("t5_isi_sat_valid", isi_valid, 1);
        checkOutput("t5_isi_saturated", isi, 4095);

        // Enable dropped mid-window: no result
        restart(9);
        applyStimulus(0, 1, 0, 9, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, (k == 1), 9, 1);
        sawValid = 0;
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 9, 1);
            if (rate_valid) sawValid = 1;
        end
        checkOutput("t6_no_partial_result", sawValid, 0);

        // Reset in the middle of a window
        applyStimulus(0, 1, 0, 9, 1);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, (k == 2 || k == 4), 9, 1);
        applyStimulus(1, 1, 0, 9, 1);
        checkOutput("t6_rst_rate_count", rate_count, 0);
        checkOutput("t6_rst_rate_valid", rate_valid, 0);
        checkOutput("t6_rst_isi", isi, 0);
        checkOutput("t6_rst_isi_valid", isi_valid, 0);
        checkOutput("t6_rst_seg", seg_out, 0);

        // Randomised traffic against the model
        wlR = 5;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) wlR = $urandom_range(0, 15);
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 39) != 0),
                          ($urandom_range(0, 2) == 0),
                          wlR,
                          ($urandom_range(0, 9) < 7));
        end
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, wlR, 1);
        checkOutput("rand_rate_results_left", rateQ.size(), 0);
        checkOutput("rand_isi_results_left", isiQ.size(), 0);
        checkOutput("rand_overrun", rate_overrun, mOverrun);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/lif_spike_monitor.md
Name: lif_spike_monitor

Overview:
Downstream consumer of the LIF neuron's spike output (uo_out[7]). Converts the raw spike line into two measurements:
- a windowed spike-rate count, delivered through a valid/ready handshake;
- an inter-spike interval (ISI), delivered as a one-cycle valid pulse.
Intended for on-chip observation of neuron firing behaviour and for driving the 7-segment readout.

Parameters:
WINDOW_W, 10, width of window_len; window length is window_len+1 cycles (1..1024)
CNT_W, 8, width of the spike counter and rate_count; saturating
ISI_W, 12, width of the ISI timer and isi; saturating

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  enable measurement; 0 forces IDLE
spike_in  input  1  spike line from LIF neuron (level, may stay high several cycles)
window_len  input  WINDOW_W  window length minus one; sampled at each window start
rate_count  output  CNT_W  spike count of last completed window
rate_valid  output  1  rate_count holds an unconsumed result
rate_ready  input  1  consumer accepts result when rate_valid&rate_ready
rate_overrun  output  1  sticky: an unconsumed result was overwritten
isi  output  ISI_W  cycles between the last two spike edges
isi_valid  output  1  one-cycle pulse when isi updates
seg_out  output  7  7-segment pattern {g,f,e,d,c,b,a}, active high (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): every register and output goes to 0, including spike_d, FSM state (IDLE), counters, rate_count, rate_valid, rate_overrun, isi, isi_valid and seg_out. Reset overrides all other activity, including mid-window.
- Edge detect: spike_d <= spike_in. event = spike_in & ~spike_d (combinational). A level held high for N cycles counts as one event.
- Window FSM, states IDLE and RUN:
  - IDLE: if en=1, load win_len_q<=window_len, win_cnt<=0, spike_cnt<=0, and go to RUN. Events in the IDLE cycle are not counted.
  - RUN, each cycle: spike_cnt <= sat(spike_cnt+event) and win_cnt <= win_cnt+1.
  - RUN, when win_cnt==win_len_q (last window cycle): result = sat(spike_cnt+event) moves to the output register; reload win_len_q<=window_len, win_cnt<=0, spike_cnt<=0. The FSM stays in RUN, so windows are back-to-back with no gap.
  - RUN with en=0: go to IDLE and discard the partial window; no result is produced.
- Rate output:
  - Latency: rate_count/rate_valid are updated on the edge that ends the last window cycle, so they are visible the next cycle.
  - rate_valid stays high until a rate_valid&rate_ready handshake, then clears.
  - New result while valid and not being consumed: overwrite rate_count, keep rate_valid=1, set rate_overrun.
  - New result in the same cycle as a handshake: load the new result, rate_valid stays 1, no overrun.
  - rate_overrun clears only on rst.
- Saturation: spike_cnt and rate_count clamp at 2^CNT_W-1; isi_timer clamps at 2^ISI_W-1.
- ISI tracking:
  - armed resets to 0. The first event with en=1 sets armed=1 and isi_timer<=1, with no isi_valid.
  - While armed and no event: isi_timer <= sat(isi_timer+1).
  - Event while armed: isi<=isi_timer, isi_valid<=1 for one cycle, isi_timer<=1.
  - Consequence: edges at cycles t0 and t1 give isi = t1-t0. An output of 2^ISI_W-1 means "at least" that many cycles.
  - en=0 clears armed and isi_timer; isi holds its last value.

Optional Feature:
SPIKE_MON_SEG7_EN
- Defined: seg_out is a registered hex decode of rate_count[3:0], updated on the cycle after rate_count changes; reset value 0. Digits 0..F use standard patterns, e.g. 3 -> 7'b1001111.
- Undefined: seg_out is tied to 7'b0000000 and no decoder logic is present.

Test Plan:
1. rst, en=1, window_len=9, rate_ready=1; 1-cycle spikes at RUN cycles 2, 5, 8 -> rate_count=3, rate_valid high exactly 1 cycle; with SPIKE_MON_SEG7_EN, seg_out=1001111 one cycle later.
2. spike_in held high 4 cycles, then low, within one window of 10 -> rate_count=1.
3. Edges 7 cycles apart, then 20 cycles apart -> first edge gives no isi_valid; isi=7 then isi=20, each with a 1-cycle isi_valid pulse.
4. rate_ready=0 across two windows with 2 then 5 spikes -> rate_count=5, rate_overrun=1. Then rate_ready=1 -> handshake, rate_valid=0; rate_overrun stays 1 until rst.
5. window_len=1023, spike_in toggling every cycle (512 edges) -> rate_count=255. No spikes for 5000 cycles after arming, then an edge -> isi=4095.
6. en dropped at cycle 4 of a window -> no rate_valid, FSM returns to IDLE. rst asserted mid-window -> all outputs 0 the next cycle.
